store_buffer: RTL and testbench
===============================

# store_buffer

Word-wide posted-write buffer between the CPU memory-access path and the data memory. CPU stores are queued in a small FIFO and drained to memory one per cycle whenever the memory port is not needed for a load. Loads are served in zero cycles, forwarding the youngest matching buffered store so the CPU always observes its own writes. The CPU stalls only when it issues a store into a full buffer.

## Interface
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears the buffer.
- CpuAddress  input  32  byte address of the CPU access.
- CpuWriteData  input  32  store data.
- CpuMemRead  input  1  CPU load request.
- CpuMemWrite  input  1  CPU store request.
- CpuReadData  output  32  load result; 0 when CpuMemRead=0.
- Stall  output  1  store not accepted this cycle; CPU holds its request.
- Empty  output  1  no stores pending.
- MemAddress  output  32  data-memory address.
- MemWriteData  output  32  data-memory write data.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- MemReadData  input  32  data-memory read data, combinational.

## Operation
- State: DEPTH entries {addr[31:0], data[31:0]}, head pointer, tail pointer, count (0..DEPTH). Pointers wrap modulo DEPTH.
- Enqueue: at posedge when CpuMemWrite=1 and count<DEPTH, write {CpuAddress, CpuWriteData} at the tail; tail+1.
- Stall = CpuMemWrite & (count==DEPTH). This is combinational from registered count. A simultaneous drain does not clear Stall in that cycle.
- Port arbitration (combinational):
  - If CpuMemRead=1: the load owns the port. MemRead=1, MemAddress=CpuAddress, MemWrite=0. No drain this cycle.
  - Else if count>0: drain the head entry. MemWrite=1, MemAddress=head.addr, MemWriteData=head.data. Head+1 at posedge.
  - Else all Mem* outputs are 0.
- Forwarding:
  - On a load, compare CpuAddress (all 32 bits) against every valid entry.
  - The youngest match, i.e. the one closest to the tail, drives CpuReadData. With no match, CpuReadData=MemReadData.
  - Matching is exact-address only. Software uses word-aligned word accesses.
- CpuMemRead=1 and CpuMemWrite=1 together:
  - The load forwards from the pre-existing contents.
  - The store enqueues at the same posedge, subject to Stall.
- Count update per posedge: +1 on enqueue, -1 on drain, unchanged when both or neither occur.
- Empty = (count==0).

## Timing
- Reset (asynchronous, immediate): count=0, head=tail=0, Empty=1, Stall=0, MemWrite=0, MemRead=CpuMemRead, CpuReadData follows the forwarding rules with an empty buffer. Pending stores are discarded, not written.
- Store issued in cycle N with no load in N+1: MemWrite=1 during N+1, and memory commits at the N+1→N+2 edge.
- Load latency is zero cycles, whether forwarded or from memory.
- A store and a load to the same address in consecutive cycles: the load sees the store's data by forwarding.
- Back-to-back loads starve draining indefinitely. Stores keep accepting until full, then Stall.
- Full buffer with no load and a store pending: cycle N has Stall=1 and a drain. Cycle N+1 has count=DEPTH-1, so the store is accepted.
- Wrap-around: the pointers roll from DEPTH-1 to 0 with no bubble, and forwarding age ordering holds across the wrap.

## Test plan
- Reset then idle: Empty=1, Stall=0, MemWrite=0, CpuReadData=0. Assert reset mid-drain with 3 entries pending: Empty=1 immediately, and no further MemWrite.
- Store 0x0000_00AA to address 8, then idle: MemWrite=1, MemAddress=8, MemWriteData=0xAA in the next cycle only. A later load of address 8 with no forwarding returns 0xAA from memory.
- Hold CpuMemRead=1 (address 0x100) while storing 0x11, 0x22, 0x33 to address 4: no MemWrite while loads continue. Then a load of address 4 forwards 0x33, the youngest.
- Load address 0 held, then 5 stores to addresses 0x10..0x20: the first 4 are accepted, the 5th sees Stall=1. Release the load: the drain order is 0x10,0x14,0x18,0x1C, the 5th store is accepted one cycle after the first drain, and memory ends holding all five values.
- 12 stores interleaved with idle cycles, crossing pointer wrap twice: every address is written exactly once in issue order, and Empty=1 at the end.
- Simultaneous load and store to address 0x40, whose prior buffered value is 7, with a new value of 9: CpuReadData=7 that cycle, and a load of 0x40 next cycle returns 9.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU data path and data memory.
// Stores queue in a small FIFO and drain when loads leave the port idle; loads forward the youngest match.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] CpuAddress,
  input  logic [31:0] CpuWriteData,
  input  logic        CpuMemRead,
  input  logic        CpuMemWrite,
  output logic [31:0] CpuReadData,
  output logic        Stall,
  output logic        Empty,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  ptr_t          head_q;
  ptr_t          tail_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          enq;
  logic          drain;
  logic [31:0]   fwd_data;
  ptr_t          idx;

  assign full  = (count_q == CW'(DEPTH));
  assign Empty = (count_q == '0);
  assign Stall = CpuMemWrite & full;
  assign enq   = CpuMemWrite & ~full;
  // A load always owns the memory port; draining waits for a load-free cycle.
  assign drain = ~CpuMemRead & ~Empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      case ({enq, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= CpuAddress;
      data_q[tail_q] <= CpuWriteData;
    end
  end

  // Walk from oldest to youngest so the last hit (closest to tail) wins.
  always_comb begin
    fwd_data = MemReadData;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == CpuAddress))
        fwd_data = data_q[idx];
    end
  end

  always_comb begin
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    CpuReadData  = '0;
    if (CpuMemRead) begin
      MemRead     = 1'b1;
      MemAddress  = CpuAddress;
      CpuReadData = fwd_data;
    end else if (drain) begin
      MemWrite     = 1'b1;
      MemAddress   = addr_q[head_q];
      MemWriteData = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a word-addressed memory model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] CpuAddress;
  logic [31:0] CpuWriteData;
  logic        CpuMemRead;
  logic        CpuMemWrite;
  logic [31:0] CpuReadData;
  logic        Stall;
  logic        Empty;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .CpuAddress(CpuAddress), .CpuWriteData(CpuWriteData),
    .CpuMemRead(CpuMemRead), .CpuMemWrite(CpuMemWrite),
    .CpuReadData(CpuReadData), .Stall(Stall), .Empty(Empty),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  assign MemReadData = mem[MemAddress[9:2]];

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[MemAddress[9:2]] <= MemWriteData;
      wlog_addr.push_back(MemAddress);
      wlog_data.push_back(MemWriteData);
    end
  end

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    CpuMemRead   = rd;
    CpuMemWrite  = wr;
    CpuAddress   = a;
    CpuWriteData = d;
    #1;
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; n < 20 && Empty !== 1'b1; n++) drive(0, 0, 0, 0);
    vectors++;
    if (Empty !== 1'b1) begin
      miscompares++;
      $display("FAIL %s drain timeout: Empty=%b expected 1", name, Empty);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    CpuMemRead = 0; CpuMemWrite = 0; CpuAddress = 0; CpuWriteData = 0;
    #1;
    vectors++;
    if ({Empty, Stall, MemWrite, MemRead} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: E/S/W/R=%b expected 1000", {Empty, Stall, MemWrite, MemRead});
    end
    vectors++;
    if (CpuReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected 0", CpuReadData);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_store;
    drive(0, 1, 32'h8, 32'hAA);
    vectors++;
    if (MemWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL single_issue_memwrite: got %b expected 0", MemWrite);
    end
    drive(0, 0, 0, 0);
    vectors++;
    if ({MemWrite, MemAddress, MemWriteData} !== {1'b1, 32'h8, 32'hAA}) begin
      miscompares++;
      $display("FAIL single_drain: W=%b A=%h D=%h expected 1/8/aa", MemWrite, MemAddress, MemWriteData);
    end
    drive(0, 0, 0, 0);
    vectors++;
    if ({MemWrite, Empty} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_after: W=%b E=%b expected 0/1", MemWrite, Empty);
    end
    drive(1, 0, 32'h8, 0);
    vectors++;
    if ({MemRead, CpuReadData} !== {1'b1, 32'hAA}) begin
      miscompares++;
      $display("FAIL single_load_mem: R=%b data=%h expected 1/aa", MemRead, CpuReadData);
    end
  endtask

  task automatic test_load_starve;
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    drive(1, 0, 32'h100, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h4, vals[i]);
      vectors++;
      if (MemWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_memwrite[%0d]: got %b expected 0", i, MemWrite);
      end
      if (i > 0) begin
        vectors++;
        if (CpuReadData !== vals[i-1]) begin
          miscompares++;
          $display("FAIL starve_fwd[%0d]: got %h expected %h", i, CpuReadData, vals[i-1]);
        end
      end
    end
    drive(1, 0, 32'h4, 0);
    vectors++;
    if ({MemWrite, CpuReadData} !== {1'b0, 32'h33}) begin
      miscompares++;
      $display("FAIL starve_youngest: W=%b data=%h expected 0/33", MemWrite, CpuReadData);
    end
    wait_empty("starve");
  endtask

  task automatic test_full_stall;
    int base;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i));
      vectors++;
      if (Stall !== 1'b0) begin
        miscompares++;
        $display("FAIL full_accept[%0d]: Stall=%b expected 0", i, Stall);
      end
    end
    drive(1, 1, 32'h20, 32'hA4);
    vectors++;
    if ({Stall, MemWrite} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_stall: S=%b W=%b expected 1/0", Stall, MemWrite);
    end
    base = wlog_addr.size();
    drive(0, 1, 32'h20, 32'hA4);
    vectors++;
    if ({Stall, MemWrite, MemAddress} !== {2'b11, 32'h10}) begin
      miscompares++;
      $display("FAIL full_first_drain: S=%b W=%b A=%h expected 1/1/10", Stall, MemWrite, MemAddress);
    end
    drive(0, 1, 32'h20, 32'hA4);
    vectors++;
    if ({Stall, MemWrite, MemAddress} !== {2'b01, 32'h14}) begin
      miscompares++;
      $display("FAIL full_accept_5th: S=%b W=%b A=%h expected 0/1/14", Stall, MemWrite, MemAddress);
    end
    wait_empty("full");
    vectors++;
    if (wlog_addr.size() !== base + 5) begin
      miscompares++;
      $display("FAIL full_write_count: got %0d expected %0d", wlog_addr.size() - base, 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if ({wlog_addr[base+i], wlog_data[base+i], mem[(32'h10 + 4*i) >> 2]}
            !== {32'h10 + 32'(4*i), 32'hA0 + 32'(i), 32'hA0 + 32'(i)}) begin
          miscompares++;
          $display("FAIL full_order[%0d]: addr=%h data=%h mem=%h expected %h/%h",
                   i, wlog_addr[base+i], wlog_data[base+i], mem[(32'h10 + 4*i) >> 2],
                   32'h10 + 32'(4*i), 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap;
    int base;
    base = wlog_addr.size();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 32'h200 + 32'(4*i), 32'h1000 + 32'(i));
      if (i % 2 == 1) drive(0, 0, 0, 0);
    end
    wait_empty("wrap");
    vectors++;
    if (wlog_addr.size() !== base + 12) begin
      miscompares++;
      $display("FAIL wrap_write_count: got %0d expected 12", wlog_addr.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if ({wlog_addr[base+i], wlog_data[base+i]} !== {32'h200 + 32'(4*i), 32'h1000 + 32'(i)}) begin
          miscompares++;
          $display("FAIL wrap_order[%0d]: addr=%h data=%h expected %h/%h", i,
                   wlog_addr[base+i], wlog_data[base+i], 32'h200 + 32'(4*i), 32'h1000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    drive(0, 1, 32'h40, 32'h7);
    drive(1, 1, 32'h40, 32'h9);
    vectors++;
    if (CpuReadData !== 32'h7) begin
      miscompares++;
      $display("FAIL simul_old: got %h expected 7", CpuReadData);
    end
    drive(1, 0, 32'h40, 0);
    vectors++;
    if (CpuReadData !== 32'h9) begin
      miscompares++;
      $display("FAIL simul_new: got %h expected 9", CpuReadData);
    end
    wait_empty("simul");
    vectors++;
    if (mem[32'h40 >> 2] !== 32'h9) begin
      miscompares++;
      $display("FAIL simul_mem: got %h expected 9", mem[32'h40 >> 2]);
    end
  endtask

  task automatic test_reset_mid_drain;
    int base;
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h80 + 32'(4*i), 32'hC0 + 32'(i));
    drive(0, 0, 0, 0);
    vectors++;
    if ({MemWrite, MemAddress} !== {1'b1, 32'h80}) begin
      miscompares++;
      $display("FAIL middrain_first: W=%b A=%h expected 1/80", MemWrite, MemAddress);
    end
    drive(0, 0, 0, 0);
    base = wlog_addr.size();
    reset = 1'b1;
    #1;
    vectors++;
    if ({Empty, MemWrite} !== 2'b10) begin
      miscompares++;
      $display("FAIL middrain_reset: E=%b W=%b expected 1/0", Empty, MemWrite);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      vectors++;
      if ({MemWrite, Empty} !== 2'b01) begin
        miscompares++;
        $display("FAIL middrain_idle[%0d]: W=%b E=%b expected 0/1", i, MemWrite, Empty);
      end
    end
    vectors++;
    if ({wlog_addr.size() == base, mem[32'h84 >> 2], mem[32'h88 >> 2]} !== {1'b1, 64'h0}) begin
      miscompares++;
      $display("FAIL middrain_discard: extra writes=%0d mem84=%h mem88=%h expected 0/0/0",
               wlog_addr.size() - base, mem[32'h84 >> 2], mem[32'h88 >> 2]);
    end
  endtask

  initial begin
    test_reset;
    test_single_store;
    test_load_starve;
    test_full_stall;
    test_wrap;
    test_simultaneous;
    test_reset_mid_drain;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
